invader_game_ctrl: RTL

Frame-synchronous game controller for the Space Invaders VGA datapath. Each video frame it collects per-pixel overlap flags from the alien, missile and player sprite generators. At the next frame boundary it commits alien kills and missile retirements, and steps the alien march timer. It runs the IDLE/PLAY/WIN/LOSE state machine and drives a registered pixel-source select that the top-level colour mux uses in place of ad-hoc priority logic.

---
 rtl/invaders_pkg.sv | 44 ++++
 rtl/invader_game_ctrl_march_timer.sv | 71 +++++++
 rtl/invader_game_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/invaders_pkg.sv
// -----------------------------------------------------------------------------
// invaders_pkg
// Shared types and helpers for the Space Invaders game controller.
//   game_state_t : IDLE/PLAY/WIN/LOSE encoding driven on game_state
//   pix_src_t    : pixel-source select consumed by the top-level colour mux
//   DEF_N_*      : default sprite counts
//   popcount()   : set-bit count of a 32-bit vector (narrower masks are
//                  zero-extended by the caller)
// -----------------------------------------------------------------------------
package invaders_pkg;

  localparam int DEF_N_ALIENS  = 5;
  localparam int DEF_N_MISSLES = 8;

  // Wide enough for a count of 0..32.
  localparam int POP_W = 6;
  typedef logic [POP_W-1:0] pop_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } game_state_t;

  typedef enum logic [2:0] {
    PIX_BG     = 3'd0,
    PIX_ALIEN  = 3'd1,
    PIX_MISSLE = 3'd2,
    PIX_PLAYER = 3'd3,
    PIX_WIN    = 3'd4,
    PIX_LOSE   = 3'd5
  } pix_src_t;

  function automatic pop_t popcount(input logic [31:0] v);
    pop_t n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + pop_t'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/invader_game_ctrl_march_timer.sv
// -----------------------------------------------------------------------------
// march_timer
// Counts PLAY frames and pulses march_step when the count reaches the current
// march period, max(MARCH_BASE - MARCH_SPEEDUP*dead_cnt, 1). The formation
// speeds up as aliens die because the period is recomputed every frame from
// the post-commit dead count.
// Ports:
//   clk        : pixel clock
//   rst        : synchronous active-high reset
//   clr        : synchronous clear at PLAY entry
//   frame_en   : one-cycle frame tick, only asserted while the game stays in PLAY
//   dead_cnt   : number of dead aliens after this frame's commit
//   march_step : registered one-cycle pulse on the cycle after frame_en
// -----------------------------------------------------------------------------
module march_timer
  import invaders_pkg::*;
#(
  parameter int MARCH_BASE    = 32,
  parameter int MARCH_SPEEDUP = 5,
  parameter int CNT_W         = $clog2(MARCH_BASE + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic frame_en,
  input  pop_t dead_cnt,
  output logic march_step
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] period;
  logic             step_q, step_d;
  int               period_i;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    period_i = MARCH_BASE - MARCH_SPEEDUP * int'(dead_cnt);
    if (period_i < 1) period_i = 1;
    period  = CNT_W'(period_i);
    cnt_inc = cnt_q + CNT_W'(1);
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    if (frame_en) begin
      // >= rather than == so a period that shrinks below the running count
      // (a kill this frame) still fires instead of wrapping.
      if (cnt_inc >= period) begin
        cnt_d  = '0;
        step_d = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
    end
  end

  assign march_step = step_q;

endmodule

// File: rtl/invader_game_ctrl.sv
// -----------------------------------------------------------------------------
// invader_game_ctrl
// Frame-synchronous game controller. During a frame it gathers sticky hit
// flags from sprite overlaps; on frame_start it commits kills, retires
// missiles, steps the march timer and advances the IDLE/PLAY/WIN/LOSE FSM.
// It also drives a registered pixel-source select for the colour mux.
// Optional feature: define INVADER_SCORE_EN to build the saturating kill
// score; otherwise score is tied to 0.
// Ports:
//   vga_clk_i, vga_rst_i : pixel clock, synchronous active-high reset
//   frame_start          : one-cycle pulse at pixel (0,0)
//   video_on             : active-display qualifier
//   alien_active[i]      : alien sprite i covers the current pixel
//   missle_active[j]     : missile sprite j covers the current pixel
//   player_active        : player sprite covers the current pixel
//   alien_landed         : alien formation reached the player line
//   start_btn            : debounced start/restart level
//   alien_alive          : live-alien mask
//   missle_kill          : one-cycle missile retire pulses
//   march_step           : one-cycle formation advance pulse
//   game_state           : IDLE=0 PLAY=1 WIN=2 LOSE=3
//   pix_src              : BG/ALIEN/MISSLE/PLAYER/WIN/LOSE select, 1-cycle latency
//   score                : kill count (INVADER_SCORE_EN only)
// -----------------------------------------------------------------------------
module invader_game_ctrl
  import invaders_pkg::*;
#(
  parameter int N_ALIENS      = DEF_N_ALIENS,
  parameter int N_MISSLES     = DEF_N_MISSLES,
  parameter int MARCH_BASE    = 32,
  parameter int MARCH_SPEEDUP = 5,
  parameter int HOLD_FRAMES   = 120
) (
  input  logic                 vga_clk_i,
  input  logic                 vga_rst_i,
  input  logic                 frame_start,
  input  logic                 video_on,
  input  logic [N_ALIENS-1:0]  alien_active,
  input  logic [N_MISSLES-1:0] missle_active,
  input  logic                 player_active,
  input  logic                 alien_landed,
  input  logic                 start_btn,
  output logic [N_ALIENS-1:0]  alien_alive,
  output logic [N_MISSLES-1:0] missle_kill,
  output logic                 march_step,
  output logic [1:0]           game_state,
  output logic [2:0]           pix_src,
  output logic [7:0]           score
);

  localparam int                HOLD_W   = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);

  game_state_t          state_q, state_d;
  pix_src_t             pix_q, pix_d;
  logic [N_ALIENS-1:0]  alive_q, alive_d;
  logic [N_ALIENS-1:0]  alien_pend_q, alien_pend_d;
  logic [N_MISSLES-1:0] missle_pend_q, missle_pend_d;
  logic [N_MISSLES-1:0] kill_q, kill_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [HOLD_W-1:0]    hold_inc;
  logic                 rel_wait_q, rel_wait_d;

  logic                 in_play;
  logic                 commit;
  logic                 capture;
  logic                 play_entry;
  logic                 march_en;
  logic [N_ALIENS-1:0]  alive_post;
  logic [N_ALIENS-1:0]  hit_alien;
  logic [N_ALIENS-1:0]  alive_view;
  logic [31:0]          dead_vec;
  pop_t                 dead_cnt;

  // ---------------------------------------------------------------------------
  // Hit capture, commit and game FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    in_play = (state_q == ST_PLAY);
    commit  = in_play && frame_start;
    capture = in_play && video_on;

    // Post-commit mask. Also used for capture so a hit on the frame_start
    // cycle cannot re-pend an alien that is dying on this very edge.
    alive_post = commit ? (alive_q & ~alien_pend_q) : alive_q;
    hit_alien  = alien_active & alive_post;

    alien_pend_d  = alien_pend_q;
    missle_pend_d = missle_pend_q;
    if (commit) begin
      alien_pend_d  = '0;
      missle_pend_d = '0;
    end
    // Applied after the clear: a hit on the frame_start cycle opens the next frame.
    if (capture && (|missle_active)) alien_pend_d  = alien_pend_d | hit_alien;
    if (capture && (|hit_alien))     missle_pend_d = missle_pend_d | missle_active;
    if (!in_play) begin
      alien_pend_d  = '0;
      missle_pend_d = '0;
    end

    kill_d  = commit ? missle_pend_q : '0;
    alive_d = alive_post;

    hold_inc = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + HOLD_W'(1);

    state_d    = state_q;
    hold_d     = hold_q;
    rel_wait_d = rel_wait_q;
    play_entry = 1'b0;

    // A restart out of WIN/LOSE arms rel_wait; the button must be released
    // before IDLE will accept another start, so one long press starts one game.
    if (!start_btn) rel_wait_d = 1'b0;

    if (frame_start) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_btn && !rel_wait_q) begin
            state_d    = ST_PLAY;
            play_entry = 1'b1;
          end
        end
        ST_PLAY: begin
          if (alive_post == '0)  state_d = ST_WIN;
          else if (alien_landed) state_d = ST_LOSE;
        end
        ST_WIN, ST_LOSE: begin
          hold_d = hold_inc;
          if ((hold_inc == HOLD_MAX) && start_btn) begin
            state_d    = ST_IDLE;
            rel_wait_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (play_entry) begin
      alive_d       = '1;
      alien_pend_d  = '0;
      missle_pend_d = '0;
      hold_d        = '0;
    end

    // The frame that ends the game does not march.
    march_en = commit && (state_d == ST_PLAY);

    dead_vec                = '0;
    dead_vec[N_ALIENS-1:0]  = ~alive_post;
    dead_cnt                = popcount(dead_vec);
  end

  // ---------------------------------------------------------------------------
  // Pixel-source select, registered to line up with the image RAM read.
  // IDLE shows the full formation, so every alien counts as live there.
  // ---------------------------------------------------------------------------
  always_comb begin
    alive_view = (state_q == ST_IDLE) ? '1 : alive_q;
    pix_d      = PIX_BG;
    if (state_q == ST_WIN)                  pix_d = PIX_WIN;
    else if (state_q == ST_LOSE)            pix_d = PIX_LOSE;
    else if (|(alien_active & alive_view))  pix_d = PIX_ALIEN;
    else if (|missle_active)                pix_d = PIX_MISSLE;
    else if (player_active)                 pix_d = PIX_PLAYER;
  end

  always_ff @(posedge vga_clk_i) begin
    if (vga_rst_i) begin
      state_q       <= ST_IDLE;
      pix_q         <= PIX_BG;
      alive_q       <= '1;
      alien_pend_q  <= '0;
      missle_pend_q <= '0;
      kill_q        <= '0;
      hold_q        <= '0;
      rel_wait_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_q         <= pix_d;
      alive_q       <= alive_d;
      alien_pend_q  <= alien_pend_d;
      missle_pend_q <= missle_pend_d;
      kill_q        <= kill_d;
      hold_q        <= hold_d;
      rel_wait_q    <= rel_wait_d;
    end
  end

  march_timer #(
    .MARCH_BASE    (MARCH_BASE),
    .MARCH_SPEEDUP (MARCH_SPEEDUP)
  ) u_march_timer (
    .clk        (vga_clk_i),
    .rst        (vga_rst_i),
    .clr        (play_entry),
    .frame_en   (march_en),
    .dead_cnt   (dead_cnt),
    .march_step (march_step)
  );

  // ---------------------------------------------------------------------------
  // Optional saturating kill score
  // ---------------------------------------------------------------------------
`ifdef INVADER_SCORE_EN
  logic [7:0]  score_q, score_d;
  logic [8:0]  score_sum;
  logic [31:0] pend_vec;

  always_comb begin
    pend_vec               = '0;
    pend_vec[N_ALIENS-1:0] = alien_pend_q;
    score_sum              = {1'b0, score_q} + 9'(popcount(pend_vec));
    score_d                = score_q;
    if (play_entry)  score_d = '0;
    else if (commit) score_d = score_sum[8] ? 8'hff : score_sum[7:0];
  end

  always_ff @(posedge vga_clk_i) begin
    if (vga_rst_i) score_q <= '0;
    else           score_q <= score_d;
  end

  assign score = score_q;
`else
  assign score = 8'h00;
`endif

  assign alien_alive = alive_q;
  assign missle_kill = kill_q;
  assign game_state  = state_q;
  assign pix_src     = pix_q;

endmodule
